// File: rtl/div_sequencer.sv
// Iterative 32-bit divider: one restoring step per cycle, with DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module div_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state_reg, state_next;
   logic [4:0]  count_reg;
   logic [31:0] rem_reg, quo_reg, div_reg, result_reg;
   logic [1:0]  op_reg;
   logic        neg_q_reg, neg_r_reg;

   logic        signed_op, a_neg, b_neg, is_zero, is_ovf, special, accept;
   logic [31:0] abs_a, abs_b, special_result;
   logic [32:0] rem_shift, trial;
   logic [31:0] step_rem, step_quo, q_fix, r_fix, fix_result;

   always_comb begin
      signed_op = ~op[0];
      a_neg     = signed_op & a[31];
      b_neg     = signed_op & b[31];
      abs_a     = a_neg ? (~a + 32'd1) : a;
      abs_b     = b_neg ? (~b + 32'd1) : b;
      is_zero   = (b == 32'd0);
      is_ovf    = signed_op && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      special   = is_zero | is_ovf;
      if (is_zero)
         special_result = op[1] ? a : 32'hFFFF_FFFF;
      else
         special_result = op[1] ? 32'd0 : 32'h8000_0000;
      accept    = (state_reg == IDLE) && start && !flush;
   end

   // rem < divisor always holds, so the 33-bit difference cannot overflow its sign bit.
   always_comb begin
      rem_shift  = {rem_reg, quo_reg[31]};
      trial      = rem_shift - {1'b0, div_reg};
      step_rem   = trial[32] ? rem_shift[31:0] : trial[31:0];
      step_quo   = {quo_reg[30:0], ~trial[32]};
      q_fix      = neg_q_reg ? (~quo_reg + 32'd1) : quo_reg;
      r_fix      = neg_r_reg ? (~rem_reg + 32'd1) : rem_reg;
      fix_result = op_reg[1] ? r_fix : q_fix;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = (state_reg != IDLE);
      done       = (state_reg == DONE);
      case (state_reg)
         IDLE: if (accept) state_next = special ? DONE : CALC;
         CALC: begin
            if (flush)                   state_next = IDLE;
            else if (count_reg == 5'd31) state_next = FIX;
         end
         FIX:  state_next = flush ? IDLE : DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg  <= 5'd0;
         rem_reg    <= 32'd0;
         quo_reg    <= 32'd0;
         div_reg    <= 32'd0;
         result_reg <= 32'd0;
         op_reg     <= 2'd0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
      end else begin
         if (accept) begin
            count_reg <= 5'd0;
            rem_reg   <= 32'd0;
            quo_reg   <= abs_a;
            div_reg   <= abs_b;
            op_reg    <= op;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
            if (special)
               result_reg <= special_result;
         end else if (state_reg == CALC && !flush) begin
            rem_reg   <= step_rem;
            quo_reg   <= step_quo;
            count_reg <= count_reg + 5'd1;
         end else if (state_reg == FIX && !flush) begin
            result_reg <= fix_result;
         end
      end
   end

   assign result = result_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: table of directed vectors, random vectors against a
// behavioural model, and hand sequences for flush, reset and start/flush priority.
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] exp;
      int          lat;
   } sb_t;

   sb_t sb[$];
   logic [31:0] last_result;

   div_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [31:0] sx, sy;
      sx = x;
      sy = y;
      if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      case (o)
         2'd0: return sx / sy;
         2'd1: return x / y;
         2'd2: return sx % sy;
         default: return x % y;
      endcase
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int elat, input string nm);
      int  lat, busy_cnt;
      sb_t e;
      sb.push_back('{exp, elat});
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      lat = 1; busy_cnt = 0;
      while (!done && lat < 100) begin
         if (busy) busy_cnt++;
         start = (lat == 5);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (done && busy) busy_cnt++;
      e = sb.pop_front();
      check({nm, " done"}, 32'(done), 32'd1);
      check({nm, " latency"}, 32'(lat), 32'(e.lat));
      check({nm, " busy cycles"}, 32'(busy_cnt), 32'(e.lat));
      check({nm, " result"}, result, e.exp);
      $display("op=%0d a=0x%08h b=0x%08h -> result=0x%08h latency=%0d", o, x, y, result, lat);
      @(negedge clk);
      check({nm, " idle after"}, {30'd0, busy, done}, 32'd0);
      check({nm, " result held"}, result, e.exp);
      last_result = e.exp;
   endtask

   vec_t vecs[12];

   initial begin
      int n;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         34};
      vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          34};
      vecs[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
      vecs[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
      vecs[4]  = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
      vecs[5]  = '{2'd3, 32'd5,          32'd0,          32'd5,          1};
      vecs[6]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      vecs[7]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
      vecs[8]  = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
      vecs[9]  = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
      vecs[10] = '{2'd0, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  34};
      vecs[11] = '{2'd2, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  34};

      reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
      last_result = 32'd0;
      #2;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", result, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i])
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

      for (int i = 0; i < 8; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         run_op(ro, ra, rb, model(ro, ra, rb),
                (rb == 0 || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 34,
                $sformatf("rnd%0d", i));
      end

      // Flush at iteration 10: no done, result keeps the prior value.
      @(negedge clk);
      op = 2'd1; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", 32'(busy), 32'd0);
      check("flush done", 32'(done), 32'd0);
      check("flush result", result, last_result);
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n++;
      end
      check("flush no late done", 32'(n), 32'd0);
      $display("flush at count 10: busy=%0d result=0x%08h", busy, result);
      run_op(2'd1, 32'd1000, 32'd3, 32'd333, 34, "after flush");

      // Flush during DONE does not suppress the pulse.
      @(negedge clk);
      op = 2'd1; a = 32'd9; b = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b1;
      #1;
      check("flush in done pulse", 32'(done), 32'd1);
      check("flush in done result", result, 32'hFFFF_FFFF);
      @(negedge clk);
      flush = 1'b0;
      check("flush in done idle", 32'(busy), 32'd0);
      $display("flush in DONE: result=0x%08h", result);

      // Asynchronous reset mid-CALC.
      @(negedge clk);
      op = 2'd1; a = 32'd77; b = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async reset busy", 32'(busy), 32'd0);
      check("async reset done", 32'(done), 32'd0);
      check("async reset result", result, 32'd0);
      $display("async reset mid-CALC: busy=%0d result=0x%08h", busy, result);
      @(negedge clk);
      reset = 1'b0;
      run_op(2'd3, 32'd77, 32'd5, 32'd2, 34, "after reset");

      // Start and flush together in IDLE: nothing accepted.
      @(negedge clk);
      op = 2'd1; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("start+flush busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("start+flush idle", {30'd0, busy, done}, 32'd0);
      $display("start+flush in IDLE: busy=%0d", busy);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high; forces the reset state immediately, with no clock required.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2 bits: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU; sampled with start.
REQ-005 SHALL have port a, input, 32 bits: dividend; sampled with start.
REQ-006 SHALL have port b, input, 32 bits: divisor; sampled with start.
REQ-007 SHALL have port flush, input, 1 bit: abort the operation in progress; used on pipeline flush.
REQ-008 SHALL have port busy, output, 1 bit: high whenever state is not IDLE; the execute stage stalls while busy and not done.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse; result is valid in that cycle.
REQ-010 SHALL have port result, output, 32 bits: quotient or remainder selected by the latched op; holds its value until the next done.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-012 SHALL latch a, b and op in IDLE on an edge with start=1 and flush=0.
REQ-013 SHALL take the special-case path for b==0: next state DONE; quotient 0xFFFFFFFF; remainder = a.
REQ-014 SHALL take the special-case path for signed op (DIV/REM) with a==0x80000000 and b==0xFFFFFFFF: next state DONE; quotient 0x80000000; remainder 0.
REQ-015 SHALL, for all other accepted operations, enter CALC with iteration counter 0.
REQ-016 SHALL take absolute values of operands at accept for signed ops; unsigned ops use operands unchanged.
REQ-017 SHALL perform in CALC one restoring step per cycle: shift {rem,quo} left by 1; trial = rem - divisor (33-bit subtract); if trial is non-negative, rem = trial and quo LSB = 1.
REQ-018 SHALL run CALC for exactly 32 cycles, counter 0..31, then go to FIX.
REQ-019 SHALL, in FIX, negate the quotient if the operand signs differ (signed ops only) and give the remainder the sign of the dividend, then go to DONE.
REQ-020 SHALL, in DONE, assert done=1 and drive result, then return to IDLE on the next edge.
REQ-021 SHALL give latency from the accepting edge to the done cycle of 34 cycles on the normal path and 1 cycle on the special-case path.
REQ-022 SHALL not accept back-to-back starts sooner than IDLE: start while busy is ignored and not queued.
REQ-023 SHALL, on flush=1 in any state, go to IDLE at the next edge with no done pulse and result unchanged.
REQ-024 SHALL give flush priority over start when both are high in IDLE: nothing is accepted.
REQ-025 SHALL ignore flush in DONE only for the current pulse: done is still asserted, then the block returns to IDLE.
REQ-026 SHALL compute results only from latched operands; a, b and op changing during an operation do not affect it.

Reset
REQ-027 SHALL, on reset, set state=IDLE, busy=0, done=0, result=0, counter=0, and clear the internal rem/quo registers.
REQ-028 SHALL, on reset asserted mid-operation, abandon the operation without a done pulse; the first start after reset release is accepted normally.

Verification
REQ-029 SHALL verify DIVU: a=100, b=7, start one cycle -> busy for 34 cycles, done 34 cycles after accept, result=14; repeat with REMU -> result=2.
REQ-030 SHALL verify signed ops: DIV a=-7 (0xFFFFFFF9), b=2 -> result 0xFFFFFFFD (-3); REM with the same operands -> result 0xFFFFFFFF (-1).
REQ-031 SHALL verify divide by zero: DIV a=5, b=0 -> done on the cycle after accept, result 0xFFFFFFFF; REMU a=5, b=0 -> result 5.
REQ-032 SHALL verify overflow: DIV a=0x80000000, b=0xFFFFFFFF -> done after 1 cycle, result 0x80000000; REM with the same operands -> result 0.
REQ-033 SHALL verify flush: flush at CALC count 10 -> IDLE next cycle, no done, result keeps its prior value; a new start then completes correctly.
REQ-034 SHALL verify reset and priority: reset asserted asynchronously mid-CALC -> busy=0 and result=0 with no clock edge; start+flush together in IDLE -> busy stays 0.
